// File: rtl/calc_pkg.sv
// Shared definitions for the calc command sequencer.
// Op encodings, FSM states and the queued command layout.
package calc_pkg;

    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_XOR = 3'b111;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b010;

    localparam int ENTRY_W = 20;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic        clr;
        logic [2:0]  op;
        logic [15:0] operand;
    } cmd_t;

endpackage

// File: rtl/calc_cmd_fifo.sv
// Command queue for calc_ctrl: DEPTH x ENTRY_W synchronous FIFO.
// A write is taken when full only if a read happens in the same cycle.
module calc_cmd_fifo
    import calc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               rd_en,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               full,
    output logic               empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               do_wr, do_rd;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap at the power-of-two depth
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(do_wr) - CW'(do_rd);
        if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    end

    // Control state with async reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, no reset needed since occupancy gates reads
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/calc_ctrl.sv
// Command sequencer replaying queued ops onto the calc datapath.
// Optional perf counters enabled by defining CALC_CTRL_PERF_EN.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int RESULT_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_clr,
    input  logic [2:0]  cmd_op,
    input  logic [15:0] cmd_operand,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        busy,
    output logic        btnc,
    output logic        btnl,
    output logic        btnr,
    output logic        btnd,
    output logic        btnu,
    output logic [15:0] sw,
    input  logic [15:0] led
`ifdef CALC_CTRL_PERF_EN
    ,
    output logic [15:0] perf_ops,
    output logic [15:0] perf_stall
`endif
);

    localparam logic [2:0] LAT = 3'(RESULT_LAT);

    state_e             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               btnd_q, btnd_d;
    logic               btnu_q, btnu_d;
    logic [2:0]         op_q, op_d;
    logic [15:0]        sw_q, sw_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [15:0]        rsp_data_q, rsp_data_d;
    logic               full, empty, push, pop;
    cmd_t               wr_cmd, head;
    logic [ENTRY_W-1:0] head_raw;

    assign wr_cmd    = '{clr: cmd_clr, op: cmd_op, operand: cmd_operand};
    assign head      = cmd_t'(head_raw);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;

    calc_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (wr_cmd),
        .rd_en   (pop),
        .rd_data (head_raw),
        .full    (full),
        .empty   (empty)
    );

    // Sequencer next-state: pop, strobe, settle, then hold the response
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        btnd_d      = 1'b0;
        btnu_d      = 1'b0;
        op_d        = op_q;
        sw_d        = sw_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        pop         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                    if (head.clr) begin
                        btnu_d = 1'b1;
                    end else begin
                        btnd_d = 1'b1;
                        op_d   = head.op;
                        sw_d   = head.operand;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = LAT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    rsp_data_d  = led;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered FSM state and every calc-facing / response output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            btnd_q      <= 1'b0;
            btnu_q      <= 1'b0;
            op_q        <= '0;
            sw_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            btnd_q      <= btnd_d;
            btnu_q      <= btnu_d;
            op_q        <= op_d;
            sw_q        <= sw_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign btnc      = op_q[2];
    assign btnl      = op_q[1];
    assign btnr      = op_q[0];
    assign btnd      = btnd_q;
    assign btnu      = btnu_q;
    assign sw        = sw_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = !empty || (state_q != S_IDLE);

`ifdef CALC_CTRL_PERF_EN
    logic [15:0] perf_ops_q, perf_ops_d;
    logic [15:0] perf_stall_q, perf_stall_d;

    // Saturating counts of issued commands and host stall cycles
    always_comb begin
        perf_ops_d   = perf_ops_q;
        perf_stall_d = perf_stall_q;
        if (state_q == S_ISSUE && perf_ops_q != 16'hFFFF)
            perf_ops_d = perf_ops_q + 16'd1;
        if (cmd_valid && full && perf_stall_q != 16'hFFFF)
            perf_stall_d = perf_stall_q + 16'd1;
    end

    // Perf counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_ops_q   <= perf_ops_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule
